// File: rtl/mips_data_mem_if.sv
// Data-side bus between mips_core and mips_data_mem.
// Lane 0 of each data bus is the most-significant byte.
interface mips_data_mem_if;
  logic        mem_req;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in  [0:3];
  logic [7:0]  mem_data_out [0:3];
  logic        mem_ready;
  logic        mem_busy;

  modport master (
    output mem_req, mem_write_en, mem_addr, mem_data_in,
    input  mem_data_out, mem_ready, mem_busy
  );

  modport slave (
    input  mem_req, mem_write_en, mem_addr, mem_data_in,
    output mem_data_out, mem_ready, mem_busy
  );
endinterface

// File: rtl/mips_data_mem.sv
// Multi-cycle word-organised data memory with request handshake
// and fixed access latency, four big-endian byte lanes.
module mips_data_mem #(
  parameter int AW      = 12,
  parameter int LATENCY = 4
) (
  input logic              clk,
  input logic              rst,
  mips_data_mem_if.slave   s
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_cnt;
  logic [3:0]     w_cnt_next;
  logic [AW-1:0]  r_addr;
  logic           r_we;
  logic [7:0]     r_din  [0:3];
  logic [7:0]     r_dout [0:3];
  logic [7:0]     r_mem  [0:3][0:(2**AW)-1];

  logic           w_accept;
  logic           w_commit;
  logic [AW-1:0]  w_c_addr;
  logic           w_c_we;
  logic [7:0]     w_c_din [0:3];
  logic           w_unused;

  assign w_unused = ^{s.mem_addr[31:AW+2], s.mem_addr[1:0]};

  assign w_accept = (r_state != S_WAIT) && s.mem_req;
  assign w_commit = (w_next == S_DONE);

  // With LATENCY=1 the access completes on the accepting edge,
  // so the live inputs are used instead of the latched copy.
  always_comb begin
    w_c_addr = s.mem_addr[AW+1:2];
    w_c_we   = s.mem_write_en;
    for (int i = 0; i < 4; i++) w_c_din[i] = s.mem_data_in[i];
    if (r_state == S_WAIT) begin
      w_c_addr = r_addr;
      w_c_we   = r_we;
      for (int i = 0; i < 4; i++) w_c_din[i] = r_din[i];
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_cnt_next = 4'(LATENCY - 1);
          w_next     = (LATENCY == 1) ? S_DONE : S_WAIT;
        end else begin
          w_next     = S_IDLE;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_next = S_DONE;
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_din   <= '{default: '0};
      r_dout  <= '{default: '0};
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr <= s.mem_addr[AW+1:2];
        r_we   <= s.mem_write_en;
        r_din  <= s.mem_data_in;
      end
      if (w_commit && !w_c_we) begin
        for (int i = 0; i < 4; i++) r_dout[i] <= r_mem[i][w_c_addr];
      end
    end
  end

  // Storage is never cleared; an edge seen under reset must not commit.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_c_we) begin
      for (int i = 0; i < 4; i++) r_mem[i][w_c_addr] <= w_c_din[i];
    end
  end

  assign s.mem_ready    = (r_state == S_DONE);
  assign s.mem_busy     = (r_state == S_WAIT);
  assign s.mem_data_out = r_dout;

endmodule
